// File: rtl/sdram_fb_arbiter.sv
// Triple-buffered SDRAM frame-buffer arbiter: issues write/read burst requests from FIFO fill
// levels and rotates three frame buffers so the display never reads the frame being captured.
module sdram_fb_arbiter #(
  parameter int                ADDR_W     = 22,
  parameter int                LEN_W      = 9,
  parameter int                LVL_W      = 10,
  parameter int                RDF_DEPTH  = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 22'h100000,
  parameter int                ARB_MODE   = 0
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic [LEN_W-1:0]  wr_length,
  input  logic [LEN_W-1:0]  rd_length,
  input  logic [ADDR_W-1:0] frame_words,
  input  logic              wr_start,
  input  logic              rd_enable,
  input  logic [LVL_W-1:0]  wrf_level,
  input  logic [LVL_W-1:0]  rdf_level,
  input  logic              sdram_init_done,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic [ADDR_W-1:0] sdram_wraddr,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  output logic [ADDR_W-1:0] sdram_rdaddr,
  output logic              rdf_flush,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf
);

  localparam int CMP_W = LVL_W + 2;
  localparam int LVW_W = LVL_W + LEN_W;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST} state_t;

  state_t              state;
  logic [1:0]          ready_buf;
  logic                fresh;
  logic                has_frame;
  logic                wr_active;
  logic                start_pend;
  logic                last_wr;
  logic [ADDR_W-1:0]   wr_off;
  logic [ADDR_W-1:0]   rd_off;

  logic                wr_lvl_ok;
  logic signed [CMP_W-1:0] rd_room;
  logic signed [CMP_W-1:0] rdf_lvl_s;
  logic                rd_space_ok;
  logic [ADDR_W:0]     wr_end;
  logic [ADDR_W:0]     rd_end;
  logic                wr_last;
  logic                rd_last;
  logic                wr_pend;
  logic                rd_pend;
  logic                grant_wr;
  logic                grant_rd;
  logic                rd_frame_start;
  logic [1:0]          rd_sel;

  function automatic logic [ADDR_W-1:0] buf_base(input logic [1:0] b);
    return BASE_ADDR + ADDR_W'(b) * BUF_STRIDE;
  endfunction

  // Room check is signed so a burst longer than the FIFO never looks like it fits.
  assign rd_room     = CMP_W'(RDF_DEPTH) - CMP_W'(rd_length);
  assign rdf_lvl_s   = $signed(CMP_W'(rdf_level));
  assign rd_space_ok = rdf_lvl_s <= rd_room;
  assign wr_lvl_ok   = LVW_W'(wrf_level) >= LVW_W'(wr_length);

  assign wr_end  = {1'b0, wr_off} + (ADDR_W+1)'(wr_length);
  assign rd_end  = {1'b0, rd_off} + (ADDR_W+1)'(rd_length);
  assign wr_last = wr_end >= {1'b0, frame_words};
  assign rd_last = rd_end >= {1'b0, frame_words};

  always_comb begin
    wr_pend = sdram_init_done & wr_active & (wr_length != '0) & wr_lvl_ok & ~wr_start;
    rd_pend = sdram_init_done & rd_enable & has_frame & (rd_length != '0) & rd_space_ok;
    if (ARB_MODE == 0) grant_wr = wr_pend;
    else               grant_wr = wr_pend & (~rd_pend | ~last_wr);
    grant_rd       = rd_pend & ~grant_wr;
    rd_frame_start = (rd_off == '0);
    rd_sel         = (rd_frame_start && fresh) ? ready_buf : rd_buf;
  end

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state            <= IDLE;
      sdram_wr_req     <= 1'b0;
      sdram_rd_req     <= 1'b0;
      sdram_wraddr     <= BASE_ADDR;
      sdram_rdaddr     <= BASE_ADDR;
      rdf_flush        <= 1'b1;
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
      wr_buf           <= 2'd0;
      ready_buf        <= 2'd1;
      rd_buf           <= 2'd2;
      fresh            <= 1'b0;
      has_frame        <= 1'b0;
      wr_active        <= 1'b0;
      start_pend       <= 1'b0;
      last_wr          <= 1'b0;
      wr_off           <= '0;
      rd_off           <= '0;
    end else begin
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
      rdf_flush        <= ~rd_enable;

      if (wr_start && (state == IDLE || state == RD_REQ || state == RD_BURST)) begin
        wr_active <= 1'b1;
        wr_off    <= '0;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            sdram_wraddr <= buf_base(wr_buf) + wr_off;
            sdram_wr_req <= 1'b1;
            last_wr      <= 1'b1;
            state        <= WR_REQ;
          end else if (grant_rd) begin
            // Frame start takes the newest completed buffer; the old one becomes the spare.
            if (rd_frame_start && fresh) begin
              rd_buf    <= ready_buf;
              ready_buf <= rd_buf;
              fresh     <= 1'b0;
            end
            sdram_rdaddr <= buf_base(rd_sel) + rd_off;
            sdram_rd_req <= 1'b1;
            last_wr      <= 1'b0;
            state        <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (wr_start) start_pend <= 1'b1;
          if (sdram_wr_ack) begin
            sdram_wr_req <= 1'b0;
            state        <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (!sdram_wr_ack) begin
            state <= IDLE;
            if (start_pend || wr_start) begin
              wr_off     <= '0;
              wr_active  <= 1'b1;
              start_pend <= 1'b0;
            end else if (wr_last) begin
              // rd_buf cannot change in this state, so it already is the next-cycle read buffer.
              wr_off           <= '0;
              wr_active        <= 1'b0;
              frame_write_done <= 1'b1;
              ready_buf        <= wr_buf;
              wr_buf           <= 2'd3 - rd_buf - wr_buf;
              fresh            <= 1'b1;
              has_frame        <= 1'b1;
            end else begin
              wr_off <= wr_off + ADDR_W'(wr_length);
            end
          end else if (wr_start) begin
            start_pend <= 1'b1;
          end
        end
        RD_REQ: begin
          if (sdram_rd_ack) begin
            sdram_rd_req <= 1'b0;
            state        <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (!sdram_rd_ack) begin
            state <= IDLE;
            if (rd_enable) begin
              if (rd_last) begin
                rd_off          <= '0;
                frame_read_done <= 1'b1;
              end else begin
                rd_off <= rd_off + ADDR_W'(rd_length);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Display off: the next read always restarts a frame.
      if (!rd_enable) rd_off <= '0;
    end
  end

endmodule

// File: tb/tb_sdram_fb_arbiter.sv
// Directed bench for sdram_fb_arbiter: two instances (fixed priority and round-robin) share stimulus,
// each with an ack responder that logs every granted burst.
module tb_sdram_fb_arbiter;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  wr_length = 9'd16;
  logic [8:0]  rd_length = 9'd16;
  logic [21:0] frame_words = 22'd64;
  logic        wr_start = 1'b0;
  logic        rd_enable = 1'b0;
  logic [9:0]  wrf_level = 10'd16;
  logic [9:0]  rdf_level = 10'd0;
  logic        init_done = 1'b1;

  logic        wr_req0, rd_req0, flush0, wdone_p0, rdone_p0;
  logic        wr_req1, rd_req1, flush1, wdone_p1, rdone_p1;
  logic        wr_ack0 = 1'b0, rd_ack0 = 1'b0, wr_ack1 = 1'b0, rd_ack1 = 1'b0;
  logic [21:0] wraddr0, rdaddr0, wraddr1, rdaddr1;
  logic [1:0]  wr_buf0, rd_buf0, wr_buf1, rd_buf1;

  typedef struct packed { logic rd; logic [21:0] addr; } ent_t;
  ent_t log0[$];
  ent_t log1[$];
  int   cnt_w0 = 0, cnt_r0 = 0, cnt_w1 = 0, cnt_r1 = 0;
  int   wdone0 = 0, viol = 0;
  int   checks = 0, failures = 0;

  sdram_fb_arbiter #(.ARB_MODE(0)) u0 (
    .clk_ref(clk_ref), .rst(rst), .wr_length(wr_length), .rd_length(rd_length),
    .frame_words(frame_words), .wr_start(wr_start), .rd_enable(rd_enable),
    .wrf_level(wrf_level), .rdf_level(rdf_level), .sdram_init_done(init_done),
    .sdram_wr_req(wr_req0), .sdram_wr_ack(wr_ack0), .sdram_wraddr(wraddr0),
    .sdram_rd_req(rd_req0), .sdram_rd_ack(rd_ack0), .sdram_rdaddr(rdaddr0),
    .rdf_flush(flush0), .frame_write_done(wdone_p0), .frame_read_done(rdone_p0),
    .wr_buf(wr_buf0), .rd_buf(rd_buf0));

  sdram_fb_arbiter #(.ARB_MODE(1)) u1 (
    .clk_ref(clk_ref), .rst(rst), .wr_length(wr_length), .rd_length(rd_length),
    .frame_words(frame_words), .wr_start(wr_start), .rd_enable(rd_enable),
    .wrf_level(wrf_level), .rdf_level(rdf_level), .sdram_init_done(init_done),
    .sdram_wr_req(wr_req1), .sdram_wr_ack(wr_ack1), .sdram_wraddr(wraddr1),
    .sdram_rd_req(rd_req1), .sdram_rd_ack(rd_ack1), .sdram_rdaddr(rdaddr1),
    .rdf_flush(flush1), .frame_write_done(wdone_p1), .frame_read_done(rdone_p1),
    .wr_buf(wr_buf1), .rd_buf(rd_buf1));

  always #5 clk_ref = ~clk_ref;

  // Responders: ack a seen request for three cycles, logging the burst address.
  always @(negedge clk_ref) begin
    if (rst) begin
      wr_ack0 = 1'b0; rd_ack0 = 1'b0; cnt_w0 = 0; cnt_r0 = 0;
    end else begin
      if (cnt_w0 != 0) begin
        cnt_w0--; if (cnt_w0 == 0) wr_ack0 = 1'b0;
      end else if (wr_req0 && !wr_ack0) begin
        log0.push_back('{rd: 1'b0, addr: wraddr0}); wr_ack0 = 1'b1; cnt_w0 = 3;
      end
      if (cnt_r0 != 0) begin
        cnt_r0--; if (cnt_r0 == 0) rd_ack0 = 1'b0;
      end else if (rd_req0 && !rd_ack0) begin
        log0.push_back('{rd: 1'b1, addr: rdaddr0}); rd_ack0 = 1'b1; cnt_r0 = 3;
        if (rdaddr0[21:20] == wr_buf0) viol++;
      end
      if (wdone_p0) wdone0++;
      if (wr_buf0 == rd_buf0 || wr_buf1 == rd_buf1) viol++;
    end
  end

  always @(negedge clk_ref) begin
    if (rst) begin
      wr_ack1 = 1'b0; rd_ack1 = 1'b0; cnt_w1 = 0; cnt_r1 = 0;
    end else begin
      if (cnt_w1 != 0) begin
        cnt_w1--; if (cnt_w1 == 0) wr_ack1 = 1'b0;
      end else if (wr_req1 && !wr_ack1) begin
        log1.push_back('{rd: 1'b0, addr: wraddr1}); wr_ack1 = 1'b1; cnt_w1 = 3;
      end
      if (cnt_r1 != 0) begin
        cnt_r1--; if (cnt_r1 == 0) rd_ack1 = 1'b0;
      end else if (rd_req1 && !rd_ack1) begin
        log1.push_back('{rd: 1'b1, addr: rdaddr1}); rd_ack1 = 1'b1; cnt_r1 = 3;
        if (rdaddr1[21:20] == wr_buf1) viol++;
      end
    end
  end

  task automatic step();
    @(negedge clk_ref);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic rd, input logic [21:0] a);
    return {9'b0, rd, a};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    steps(3);
    check("rst_wr_req", {31'b0, wr_req0}, 0);
    check("rst_rd_req", {31'b0, rd_req0}, 0);
    check("rst_wraddr", {10'b0, wraddr0}, 0);
    check("rst_rdaddr", {10'b0, rdaddr0}, 0);
    check("rst_flush", {31'b0, flush0}, 1);
    check("rst_wr_buf", {30'b0, wr_buf0}, 0);
    check("rst_rd_buf", {30'b0, rd_buf0}, 2);
    check("rst_wdone", {31'b0, wdone_p0}, 0);
    rst = 1'b0;
    steps(2);

    // One full frame of writes into buffer 0
    wr_start = 1'b1; step(); wr_start = 1'b0;
    for (int i = 0; i < 300 && wdone_p0 !== 1'b1; i++) step();
    check("a_done_seen", {31'b0, wdone_p0}, 1);
    steps(5);
    check("a_log_size", log0.size(), 4);
    check("a_w0", log0[0], ent(0, 22'h000000));
    check("a_w1", log0[1], ent(0, 22'h000010));
    check("a_w2", log0[2], ent(0, 22'h000020));
    check("a_w3", log0[3], ent(0, 22'h000030));
    check("a_done_once", wdone0, 1);
    check("a_wr_buf", {30'b0, wr_buf0}, 1);
    log0.delete(); log1.delete();

    // Reader picks up the fresh buffer 0 and reads one frame
    rd_enable = 1'b1;
    for (int i = 0; i < 300 && rdone_p0 !== 1'b1; i++) step();
    check("b_rdone_seen", {31'b0, rdone_p0}, 1);
    rdf_level = 10'd1023;
    check("b_rd_buf", {30'b0, rd_buf0}, 0);
    check("b_r0", log0[0], ent(1, 22'h000000));
    check("b_r3", log0[3], ent(1, 22'h000030));
    steps(10);
    log0.delete(); log1.delete();

    // Contention: fixed priority vs round-robin; reader switches only at frame start
    wr_start = 1'b1; step(); wr_start = 1'b0; rdf_level = 10'd0;
    for (int i = 0; i < 400 && log1.size() < 9; i++) step();
    check("c_u1_size", {31'b0, log1.size() >= 9}, 1);
    check("c_u1_0", log1[0], ent(0, 22'h100000));
    check("c_u1_1", log1[1], ent(1, 22'h000000));
    check("c_u1_2", log1[2], ent(0, 22'h100010));
    check("c_u1_3", log1[3], ent(1, 22'h000010));
    check("c_u1_4", log1[4], ent(0, 22'h100020));
    check("c_u1_5", log1[5], ent(1, 22'h000020));
    check("c_u1_6", log1[6], ent(0, 22'h100030));
    check("c_u1_7", log1[7], ent(1, 22'h000030));
    check("c_u1_8", log1[8], ent(1, 22'h100000));
    check("c_u0_0", log0[0], ent(0, 22'h100000));
    check("c_u0_1", log0[1], ent(0, 22'h100010));
    check("c_u0_2", log0[2], ent(0, 22'h100020));
    check("c_u0_3", log0[3], ent(0, 22'h100030));
    check("c_u0_4", log0[4], ent(1, 22'h100000));
    check("c_u0_wr_buf", {30'b0, wr_buf0}, 2);
    check("c_u1_wr_buf", {30'b0, wr_buf1}, 2);

    // Restart a frame while the burst at offset 32 is in flight
    rdf_level = 10'd1023;
    steps(12);
    log0.delete(); log1.delete();
    begin
      int wd0;
      wd0 = wdone0;
      wr_start = 1'b1; step(); wr_start = 1'b0;
      for (int i = 0; i < 300 && !(wr_ack0 && wraddr0 == 22'h200020); i++) step();
      check("d_burst32_seen", {31'b0, wr_ack0 && wraddr0 == 22'h200020}, 1);
      wr_start = 1'b1; step(); wr_start = 1'b0;
      for (int i = 0; i < 300 && log0.size() < 7; i++) step();
      steps(10);
      check("d_w2", log0[2], ent(0, 22'h200020));
      check("d_restart", log0[3], ent(0, 22'h200000));
      check("d_w6", log0[6], ent(0, 22'h200030));
      check("d_one_done", wdone0, wd0 + 1);
      check("d_wr_buf", {30'b0, wr_buf0}, 0);
    end

    // Display off/on: flush and restart at offset 0 of the newest buffer
    rd_enable = 1'b0; rdf_level = 10'd0;
    steps(2);
    check("e_flush_off", {31'b0, flush0}, 1);
    log0.delete(); log1.delete();
    rd_enable = 1'b1; step();
    check("e_flush_on", {31'b0, flush0}, 0);
    for (int i = 0; i < 300 && log0.size() < 2; i++) step();
    rd_enable = 1'b0; step();
    check("e_flush_drop", {31'b0, flush0}, 1);
    steps(8);
    rd_enable = 1'b1;
    for (int i = 0; i < 300 && log0.size() < 3; i++) step();
    check("e_r0", log0[0], ent(1, 22'h200000));
    check("e_r1", log0[1], ent(1, 22'h200010));
    check("e_r2_restart", log0[2], ent(1, 22'h200000));
    check("e_rd_buf", {30'b0, rd_buf0}, 2);

    // Read FIFO room boundary: 504 blocks a 16-word burst, 496 allows it
    rdf_level = 10'd504;
    steps(10);
    begin
      int n;
      n = log0.size();
      steps(20);
      check("e_no_rd_504", log0.size(), n);
      check("e_rd_req_504", {31'b0, rd_req0}, 0);
      rdf_level = 10'd496;
      steps(20);
      check("e_rd_496", {31'b0, log0.size() > n}, 1);
    end

    // Reset during a read burst, then init_done gating
    rdf_level = 10'd0;
    for (int i = 0; i < 300 && rd_ack0 !== 1'b1; i++) step();
    check("f_rd_ack_seen", {31'b0, rd_ack0}, 1);
    step();
    rst = 1'b1; step();
    check("f_wr_req", {31'b0, wr_req0}, 0);
    check("f_rd_req", {31'b0, rd_req0}, 0);
    check("f_rd_buf", {30'b0, rd_buf0}, 2);
    check("f_wr_buf", {30'b0, wr_buf0}, 0);
    check("f_rdaddr", {10'b0, rdaddr0}, 0);
    rst = 1'b0;
    log0.delete(); log1.delete();
    steps(15);
    check("f_no_frame", log0.size(), 0);
    init_done = 1'b0;
    wr_start = 1'b1; step(); wr_start = 1'b0;
    steps(15);
    check("f_init_gate", log0.size(), 0);
    init_done = 1'b1;
    for (int i = 0; i < 100 && log0.size() < 1; i++) step();
    check("f_first_w", log0[0], ent(0, 22'h000000));

    check("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
